// File: rtl/lives_gameover_controller_pkg.sv
// Shared types and default geometry/timing for the lives / game-over controller.
package lives_gameover_controller_pkg;

  typedef enum logic [1:0] {ARM, PLAY, MISS, OVER} state_t;

  localparam int HRES          = 640;
  localparam int VRES          = 480;
  localparam int PADDLE_H      = 16;
  localparam int PADDLE_ROW    = VRES - PADDLE_H;
  localparam int LIVES         = 3;
  localparam int LIVES_W       = 2;
  localparam int MISS_PAUSE    = 60;
  localparam int RESTART_PAUSE = 120;
  localparam int PAUSE_W       = 8;
  localparam int OVL_VSTART    = 200;
  localparam int OVL_H         = 64;
  localparam int OVL_AW        = $clog2(OVL_H);
  localparam logic [23:0] COLOR_GMO = 24'hFF0000;

  // Byte idx of an RGB word: 0 = B, 1 = G, 2 = R.
  function automatic logic [7:0] color_byte(input logic [23:0] c, input int unsigned idx);
    return c[8*idx +: 8];
  endfunction

endpackage

// File: rtl/lives_gameover_controller_if.sv
// Game-side signal bundle of the lives / game-over controller.
// master: the controller itself; slave: the surrounding game top.
interface lives_gameover_controller_if #(
  parameter int LIVES_W = lives_gameover_controller_pkg::LIVES_W,
  parameter int OVL_AW  = lives_gameover_controller_pkg::OVL_AW,
  parameter int HRES    = lives_gameover_controller_pkg::HRES
);
  logic                fsync;
  logic                active_obj;
  logic                active_paddle;
  logic                alien_reached_paddle;
  logic signed [11:0]  hpos;
  logic signed [11:0]  vpos;
  logic [OVL_AW-1:0]   rom_addr;
  logic [HRES-1:0]     rom_data;
  logic                game_over;
  logic                freeze;
  logic                life_lost;
  logic [LIVES_W-1:0]  lives;
  logic                use_overlay;
  logic [7:0]          pixel_overlay [0:2];

  modport master (
    input  fsync, active_obj, active_paddle, alien_reached_paddle, hpos, vpos, rom_data,
    output rom_addr, game_over, freeze, life_lost, lives, use_overlay, pixel_overlay
  );

  modport slave (
    output fsync, active_obj, active_paddle, alien_reached_paddle, hpos, vpos, rom_data,
    input  rom_addr, game_over, freeze, life_lost, lives, use_overlay, pixel_overlay
  );
endinterface

// File: rtl/lives_gameover_controller_overlay_pixel_pipe.sv
// Two-stage overlay pixel path aligned to a synchronous bitmap ROM (rom_data
// valid one cycle after rom_addr); output lags hpos/vpos by two pixel clocks.
module overlay_pixel_pipe
  import lives_gameover_controller_pkg::*;
#(
  parameter int          HRES       = 640,
  parameter int          OVL_VSTART = 200,
  parameter int          OVL_H      = 64,
  parameter int          OVL_AW     = 6,
  parameter logic [23:0] OVL_COLOR  = 24'hFF0000
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  output logic [OVL_AW-1:0]  rom_addr,
  input  logic [HRES-1:0]    rom_data,
  output logic [7:0]         pixel_overlay [0:2]
);
  localparam int HW = $clog2(HRES);

  logic          in_win;
  logic          in_win_d;
  logic [HW-1:0] hpos_d;
  logic          lit;

  assign rom_addr = OVL_AW'(vpos - 12'(OVL_VSTART));

  assign in_win = (int'(vpos) >= OVL_VSTART) && (int'(vpos) < OVL_VSTART + OVL_H) &&
                  (int'(hpos) >= 0) && (int'(hpos) < HRES);

  // Column forced to 0 outside the window so rom_data is never indexed past HRES-1.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      in_win_d <= 1'b0;
      hpos_d   <= '0;
    end else begin
      in_win_d <= in_win;
      hpos_d   <= in_win ? HW'(hpos) : '0;
    end
  end

  assign lit = en && in_win_d && rom_data[hpos_d];

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) pixel_overlay[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++)
        pixel_overlay[i] <= lit ? color_byte(OVL_COLOR, i) : '0;
    end
  end

endmodule

// File: rtl/lives_gameover_controller.sv
// Lives / miss / game-over controller with frozen pauses and a ROM bitmap overlay.
// Optional GAMEOVER_BLINK_EN: overlay blinks 16 frames on / 16 off during OVER.
module lives_gameover_controller #(
  parameter int          LIVES         = lives_gameover_controller_pkg::LIVES,
  parameter int          LIVES_W       = lives_gameover_controller_pkg::LIVES_W,
  parameter int          MISS_PAUSE    = lives_gameover_controller_pkg::MISS_PAUSE,
  parameter int          RESTART_PAUSE = lives_gameover_controller_pkg::RESTART_PAUSE,
  parameter int          PAUSE_W       = lives_gameover_controller_pkg::PAUSE_W,
  parameter int          PADDLE_ROW    = lives_gameover_controller_pkg::PADDLE_ROW,
  parameter int          OVL_VSTART    = lives_gameover_controller_pkg::OVL_VSTART,
  parameter int          OVL_H         = lives_gameover_controller_pkg::OVL_H,
  parameter int          HRES          = lives_gameover_controller_pkg::HRES,
  parameter logic [23:0] OVL_COLOR     = lives_gameover_controller_pkg::COLOR_GMO
) (
  input  logic                         pixel_clk,
  input  logic                         rst,
  lives_gameover_controller_if.master  bus
);
  import lives_gameover_controller_pkg::*;

  localparam int AW = $clog2(OVL_H);

  logic [1:0]         rst_q;
  logic               rst_i;
  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [PAUSE_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic               life_lost_q, life_lost_d;
  logic               ball_q, ball_d, hit_q, hit_d, alien_q, alien_d;
  logic               on_row;
  logic               ovl_en;

  // Reset asserts asynchronously, releases two clocks after rst falls.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end
  assign rst_i = rst_q[1];

  always_ff @(posedge pixel_clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARM;
      lives_q     <= LIVES_W'(LIVES);
      cnt_q       <= '0;
      life_lost_q <= 1'b0;
      ball_q      <= 1'b0;
      hit_q       <= 1'b0;
      alien_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      life_lost_q <= life_lost_d;
      ball_q      <= ball_d;
      hit_q       <= hit_d;
      alien_q     <= alien_d;
    end
  end

  assign on_row  = bus.active_obj && (int'(bus.vpos) == PADDLE_ROW);
  assign cnt_inc = cnt_q + PAUSE_W'(1);

  // Pause counters count the fsync itself, so a pause of N releases on the
  // Nth fsync after entry and play is frozen for exactly N frames.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    cnt_d       = cnt_q;
    life_lost_d = 1'b0;
    ball_d      = ball_q;
    hit_d       = hit_q;
    alien_d     = alien_q;
    case (state_q)
      ARM: begin
        ball_d  = 1'b0;
        hit_d   = 1'b0;
        alien_d = 1'b0;
        if (bus.fsync) state_d = PLAY;
      end
      PLAY: begin
        if (bus.fsync) begin
          ball_d  = 1'b0;
          hit_d   = 1'b0;
          alien_d = 1'b0;
          cnt_d   = '0;
          if (alien_q) begin
            state_d = OVER;
            lives_d = '0;
          end else if (ball_q && !hit_q) begin
            life_lost_d = 1'b1;
            if (lives_q > LIVES_W'(1)) begin
              state_d = MISS;
              lives_d = lives_q - LIVES_W'(1);
            end else begin
              state_d = OVER;
              lives_d = '0;
            end
          end
        end else begin
          if (on_row)                      ball_d  = 1'b1;
          if (on_row && bus.active_paddle) hit_d   = 1'b1;
          if (bus.alien_reached_paddle)    alien_d = 1'b1;
        end
      end
      MISS: begin
        ball_d  = 1'b0;
        hit_d   = 1'b0;
        alien_d = 1'b0;
        if (bus.fsync) begin
          if (cnt_inc == PAUSE_W'(MISS_PAUSE)) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      OVER: begin
        ball_d  = 1'b0;
        hit_d   = 1'b0;
        alien_d = 1'b0;
        if (bus.fsync) begin
          if (cnt_inc == PAUSE_W'(RESTART_PAUSE)) begin
            state_d = PLAY;
            lives_d = LIVES_W'(LIVES);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  assign bus.game_over   = (state_q == OVER);
  assign bus.freeze      = (state_q == MISS) || (state_q == OVER);
  assign bus.use_overlay = bus.game_over;
  assign bus.life_lost   = life_lost_q;
  assign bus.lives       = lives_q;

`ifdef GAMEOVER_BLINK_EN
  assign ovl_en = bus.game_over && !cnt_q[4];
`else
  assign ovl_en = bus.game_over;
`endif

  overlay_pixel_pipe #(
    .HRES       (HRES),
    .OVL_VSTART (OVL_VSTART),
    .OVL_H      (OVL_H),
    .OVL_AW     (AW),
    .OVL_COLOR  (OVL_COLOR)
  ) u_pipe (
    .pixel_clk     (pixel_clk),
    .rst           (rst_i),
    .en            (ovl_en),
    .hpos          (bus.hpos),
    .vpos          (bus.vpos),
    .rom_addr      (bus.rom_addr),
    .rom_data      (bus.rom_data),
    .pixel_overlay (bus.pixel_overlay)
  );

endmodule

// File: tb/tb_lives_gameover_controller.sv
// Directed bench for lives_gameover_controller: vector table for play frames,
// hand-written sequences for pauses, game-over, overlay pixels and reset.
module tb_lives_gameover_controller;
  import lives_gameover_controller_pkg::*;

  logic pixel_clk = 1'b0;
  logic rst;
  always #5 pixel_clk = ~pixel_clk;

  lives_gameover_controller_if bus ();

  lives_gameover_controller dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (bus.master)
  );

  // Bitmap ROM model: bit 100 lit on every row, bit 300 additionally on row 5.
  function automatic logic [HRES-1:0] rom_model(input logic [OVL_AW-1:0] a);
    logic [HRES-1:0] r;
    r = '0;
    r[100] = 1'b1;
    if (a == OVL_AW'(5)) r[300] = 1'b1;
    return r;
  endfunction

  always_ff @(posedge pixel_clk) bus.rom_data <= rom_model(bus.rom_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix_bgr();
    return {bus.pixel_overlay[0], bus.pixel_overlay[1], bus.pixel_overlay[2]};
  endfunction

  // One frame of content, then the fsync that judges it; returns just after
  // the fsync has been registered.
  task automatic run_frame(input logic ball, input logic pad, input logic al, input logic row);
    bus.vpos                 = row ? 12'(PADDLE_ROW) : 12'(PADDLE_ROW - 1);
    bus.hpos                 = 12'sd50;
    bus.active_obj           = ball;
    bus.active_paddle        = pad;
    bus.alien_reached_paddle = al;
    @(negedge pixel_clk);
    bus.active_obj           = 1'b0;
    bus.active_paddle        = 1'b0;
    bus.alien_reached_paddle = 1'b0;
    bus.vpos                 = '0;
    bus.hpos                 = '0;
    @(negedge pixel_clk);
    bus.fsync = 1'b1;
    @(negedge pixel_clk);
    bus.fsync = 1'b0;
  endtask

  task automatic pix(input string nm, input int h, input int v,
                     input logic [5:0] exp_addr, input logic [23:0] exp);
    bus.hpos = 12'(h);
    bus.vpos = 12'(v);
    #1;
    chk({nm, " rom_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    @(negedge pixel_clk);
    chk({nm, " latency1"}, 32'(pix_bgr()), 32'h0);
    @(negedge pixel_clk);
    chk({nm, " pixel"}, 32'(pix_bgr()), 32'(exp));
    bus.hpos = '0;
    bus.vpos = '0;
    repeat (2) @(negedge pixel_clk);
  endtask

  typedef struct {
    logic       ball;
    logic       pad;
    logic       al;
    logic       row;
    logic [1:0] lives;
    logic       ll;
    logic       fr;
    logic       go;
  } vec_t;

  vec_t vecs [6];
  logic any_ll;
  logic [23:0] blink_exp;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0};  // hit
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0};  // hit
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0};  // hit
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};  // ball one row above
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0};  // paddle only
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0};  // miss

    bus.fsync = 1'b0; bus.active_obj = 1'b0; bus.active_paddle = 1'b0;
    bus.alien_reached_paddle = 1'b0; bus.hpos = '0; bus.vpos = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge pixel_clk);
    chk("reset lives", 32'(bus.lives), 32'd3);
    chk("reset game_over", 32'(bus.game_over), 32'd0);
    chk("reset freeze", 32'(bus.freeze), 32'd0);
    chk("reset life_lost", 32'(bus.life_lost), 32'd0);
    chk("reset use_overlay", 32'(bus.use_overlay), 32'd0);
    chk("reset pixel", 32'(pix_bgr()), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge pixel_clk);

    // Miss content before the first fsync is not judged.
    run_frame(1'b1, 1'b0, 1'b0, 1'b1);
    chk("arm lives", 32'(bus.lives), 32'd3);
    chk("arm life_lost", 32'(bus.life_lost), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].ball, vecs[i].pad, vecs[i].al, vecs[i].row);
      chk($sformatf("vec%0d lives", i), 32'(bus.lives), 32'(vecs[i].lives));
      chk($sformatf("vec%0d life_lost", i), 32'(bus.life_lost), 32'(vecs[i].ll));
      chk($sformatf("vec%0d freeze", i), 32'(bus.freeze), 32'(vecs[i].fr));
      chk($sformatf("vec%0d game_over", i), 32'(bus.game_over), 32'(vecs[i].go));
      @(negedge pixel_clk);
      chk($sformatf("vec%0d pulse width", i), 32'(bus.life_lost), 32'd0);
    end

    // Miss pause: misses inside MISS ignored, freeze exactly 60 frames.
    any_ll = 1'b0;
    for (int f = 1; f <= 60; f++) begin
      run_frame(1'b1, 1'b0, 1'b0, 1'b1);
      any_ll |= bus.life_lost;
      if (f == 59) begin
        chk("miss f59 freeze", 32'(bus.freeze), 32'd1);
        chk("miss f59 lives", 32'(bus.lives), 32'd2);
      end
      if (f == 60) chk("miss f60 freeze", 32'(bus.freeze), 32'd0);
    end
    chk("miss no pulse", 32'(any_ll), 32'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post miss lives", 32'(bus.lives), 32'd2);
    chk("post miss freeze", 32'(bus.freeze), 32'd0);

    run_frame(1'b1, 1'b0, 1'b0, 1'b1);
    chk("miss2 lives", 32'(bus.lives), 32'd1);
    chk("miss2 life_lost", 32'(bus.life_lost), 32'd1);
    repeat (60) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("miss2 release", 32'(bus.freeze), 32'd0);

    run_frame(1'b1, 1'b0, 1'b0, 1'b1);
    chk("miss3 lives", 32'(bus.lives), 32'd0);
    chk("miss3 life_lost", 32'(bus.life_lost), 32'd1);
    chk("miss3 game_over", 32'(bus.game_over), 32'd1);
    chk("miss3 freeze", 32'(bus.freeze), 32'd1);
    chk("miss3 use_overlay", 32'(bus.use_overlay), 32'd1);
    @(negedge pixel_clk);
    chk("miss3 pulse width", 32'(bus.life_lost), 32'd0);

    pix("ovl hit", 100, OVL_VSTART + 5, 6'd5, 24'h0000FF);
    pix("ovl above", 100, OVL_VSTART - 1, 6'd63, 24'h0);
    pix("ovl dark bit", 101, OVL_VSTART + 5, 6'd5, 24'h0);
    pix("ovl row5 bit300", 300, OVL_VSTART + 5, 6'd5, 24'h0000FF);
    pix("ovl neg hpos", -1, OVL_VSTART + 5, 6'd5, 24'h0);
    pix("ovl last row", 100, OVL_VSTART + OVL_H - 1, 6'd63, 24'h0000FF);
    pix("ovl below", 100, OVL_VSTART + OVL_H, 6'd0, 24'h0);

`ifdef GAMEOVER_BLINK_EN
    blink_exp = 24'h0;
`else
    blink_exp = 24'h0000FF;
`endif
    for (int f = 1; f <= 120; f++) begin
      run_frame(1'b0, 1'b0, 1'b0, 1'b0);
      if (f == 20) pix("ovl frame20", 100, OVL_VSTART + 5, 6'd5, blink_exp);
      if (f == 119) begin
        chk("over f119 game_over", 32'(bus.game_over), 32'd1);
        chk("over f119 lives", 32'(bus.lives), 32'd0);
      end
      if (f == 120) begin
        chk("over f120 game_over", 32'(bus.game_over), 32'd0);
        chk("over f120 lives", 32'(bus.lives), 32'd3);
        chk("over f120 freeze", 32'(bus.freeze), 32'd0);
        chk("over f120 use_overlay", 32'(bus.use_overlay), 32'd0);
      end
    end
    pix("ovl in play", 100, OVL_VSTART + 5, 6'd5, 24'h0);

    // Alien landing and miss in the same frame: alien wins, no pulse.
    run_frame(1'b1, 1'b0, 1'b1, 1'b1);
    chk("alien lives", 32'(bus.lives), 32'd0);
    chk("alien life_lost", 32'(bus.life_lost), 32'd0);
    chk("alien game_over", 32'(bus.game_over), 32'd1);
    repeat (120) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("alien restart game_over", 32'(bus.game_over), 32'd0);
    chk("alien restart lives", 32'(bus.lives), 32'd3);

    // Asynchronous reset in the middle of a miss pause.
    run_frame(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst miss lives", 32'(bus.lives), 32'd2);
    repeat (30) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst pre freeze", 32'(bus.freeze), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst async lives", 32'(bus.lives), 32'd3);
    chk("rst async freeze", 32'(bus.freeze), 32'd0);
    chk("rst async game_over", 32'(bus.game_over), 32'd0);
    chk("rst async pixel", 32'(pix_bgr()), 32'd0);
    @(negedge pixel_clk);
    rst = 1'b0;
    repeat (4) @(negedge pixel_clk);
    run_frame(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rearm lives", 32'(bus.lives), 32'd3);
    chk("rearm freeze", 32'(bus.freeze), 32'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rearm play lives", 32'(bus.lives), 32'd3);
    chk("rearm play life_lost", 32'(bus.life_lost), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
